uart_tx_arbiter: RTL and testbench

- Shares one uart_tx byte channel between NUM_REQ independent byte-stream requesters, e.g. the banner sender, the echo path and a status reporter.
- Arbitrates round-robin at packet granularity. A grant is held until the requester's byte flagged last is accepted, so messages never interleave on the serial line.
- Sits between the requesters and the uart_tx valid/ready interface. The output is registered.

---
 rtl/uart_tx_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//
// Shares one uart_tx byte channel between NUM_REQ byte-stream requesters. Arbitration is
// round-robin at packet granularity: once a requester is granted it keeps the channel until
// its byte flagged last is accepted, so packets never interleave on the serial line. The
// byte toward uart_tx sits in a single output register.
//
// Optional feature (compile-time macro UART_ARB_TIMEOUT_EN):
//   When defined, a granted requester that leaves req_valid low for TIMEOUT_CYC cycles in
//   the middle of a packet loses the grant, and timeout_flag pulses for one cycle. When
//   undefined, timeout_flag is tied low and the grant is held until req_last.
//
// Ports:
//   clk            system clock
//   rst            asynchronous reset, active-high
//   req_data       byte from requester i at bits [8i+7:8i]
//   req_valid      per-requester byte valid
//   req_last       per-requester last-byte-of-packet, qualified by req_valid
//   req_ready      per-requester accept strobe (only the owner can see it high)
//   tx_data        registered byte to uart_tx
//   tx_data_valid  registered byte valid to uart_tx
//   tx_data_ready  uart_tx ready
//   grant          one-hot current owner, zero when idle
//   busy           high while a packet is owned
//   timeout_flag   one-cycle pulse on forced release
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ     = 3,
    parameter int unsigned TIMEOUT_CYC = 50000000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_data_valid,
    input  logic                 tx_data_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 busy,
    output logic                 timeout_flag
);

    localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [0:0] {StIdle, StXfer} state_e;

    state_e          state_q, state_d;
    logic [PtrW-1:0] owner_q, owner_d;
    logic [PtrW-1:0] rr_ptr_q, rr_ptr_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            tx_valid_q, tx_valid_d;

    logic            pick_found;
    logic [PtrW-1:0] pick_idx;
    logic [PtrW-1:0] scan_ptr;
    int unsigned     scan_idx;

    logic            accept;
    logic            accept_last;
    logic [7:0]      accept_data;
    logic [PtrW-1:0] rr_next;
    logic            to_fire;

    // Round-robin pick: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        scan_idx   = 0;
        scan_ptr   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            scan_idx = (32'(rr_ptr_q) + k) % NUM_REQ;
            scan_ptr = PtrW'(scan_idx);
            if (!pick_found && req_valid[scan_ptr]) begin
                pick_found = 1'b1;
                pick_idx   = scan_ptr;
            end
        end
    end

    always_comb begin
        grant = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            grant[i] = (state_q == StXfer) && (owner_q == PtrW'(i));
        end
    end

    // The owner may hand over a byte whenever the output register is empty or draining.
    assign req_ready   = grant & {NUM_REQ{~tx_valid_q | tx_data_ready}};
    assign accept      = |(req_valid & req_ready);
    assign accept_last = accept & req_last[owner_q];
    assign accept_data = req_data[{owner_q, 3'b000} +: 8];
    assign rr_next     = (owner_q == PtrW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

`ifdef UART_ARB_TIMEOUT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic        timeout_q;

    // Counts consecutive owned cycles with the owner's valid low; any accept restarts it.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        to_fire     = 1'b0;
        if (state_q != StXfer || accept) begin
            stall_cnt_d = '0;
        end else if (!req_valid[owner_q]) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
            to_fire     = (stall_cnt_d >= TIMEOUT_CYC);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            timeout_q   <= to_fire;
        end
    end

    assign timeout_flag = timeout_q;
`else
    assign to_fire      = 1'b0;
    assign timeout_flag = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    state_d = StXfer;
                    owner_d = pick_idx;
                end
            end
            StXfer: begin
                if (accept_last || to_fire) begin
                    state_d  = StIdle;
                    rr_ptr_d = rr_next;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output register: a load always wins over a drain in the same cycle.
    always_comb begin
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        if (accept) begin
            tx_data_d  = accept_data;
            tx_valid_d = 1'b1;
        end else if (tx_valid_q && tx_data_ready) begin
            tx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
        end
    end

    assign tx_data       = tx_data_q;
    assign tx_data_valid = tx_valid_q;
    assign busy          = (state_q == StXfer);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter (NUM_REQ=3, TIMEOUT_CYC=16).
// Requesters are modelled by per-index byte queues; the expected output order of each
// scenario is pushed to a scoreboard and popped on every uart_tx handshake.
module tb_uart_tx_arbiter;

    localparam int unsigned NumReq     = 3;
    localparam int unsigned TimeoutCyc = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [8*NumReq-1:0]  req_data;
    logic [NumReq-1:0]    req_valid;
    logic [NumReq-1:0]    req_last;
    logic [NumReq-1:0]    req_ready;
    logic [7:0]           tx_data;
    logic                 tx_data_valid;
    logic                 tx_data_ready;
    logic [NumReq-1:0]    grant;
    logic                 busy;
    logic                 timeout_flag;

    uart_tx_arbiter #(
        .NUM_REQ    (NumReq),
        .TIMEOUT_CYC(TimeoutCyc)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_data     (req_data),
        .req_valid    (req_valid),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .tx_data      (tx_data),
        .tx_data_valid(tx_data_valid),
        .tx_data_ready(tx_data_ready),
        .grant        (grant),
        .busy         (busy),
        .timeout_flag (timeout_flag)
    );

    always #5 clk = ~clk;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;

    logic [8:0]        src_q [NumReq][$];  // {last, data}
    logic [7:0]        sb [$];
    logic [NumReq-1:0] en = '1;
    logic [NumReq-1:0] exp_grant_chk = '0;
    logic              track_idle = 1'b0;
    int unsigned       idle_cnt = 0;
    logic              to_seen = 1'b0;

    // Values sampled on the falling edge of the most recent cycle.
    logic [NumReq-1:0] s_grant, s_ready;
    logic              s_busy, s_txv, s_to;
    logic [7:0]        s_txd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic src_pending();
        logic p;
        p = 1'b0;
        for (int i = 0; i < NumReq; i++) if (src_q[i].size() > 0) p = 1'b1;
        return p;
    endfunction

    task automatic drive();
        for (int i = 0; i < NumReq; i++) begin
            if (en[i] && src_q[i].size() > 0) begin
                req_valid[i]       = 1'b1;
                req_data[8*i +: 8] = src_q[i][0][7:0];
                req_last[i]        = src_q[i][0][8];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[8*i +: 8] = 8'h00;
                req_last[i]        = 1'b0;
            end
        end
    endtask

    task automatic push_byte(input int idx, input logic [7:0] d, input logic last);
        src_q[idx].push_back({last, d});
    endtask

    // One clock: sample and score at the falling edge, advance requesters after the rise.
    task automatic cycle();
        logic [NumReq-1:0] fire;
        logic [7:0]        exp_b;
        @(negedge clk);
        s_grant = grant;
        s_ready = req_ready;
        s_busy  = busy;
        s_txv   = tx_data_valid;
        s_txd   = tx_data;
        s_to    = timeout_flag;
        if (timeout_flag === 1'b1) to_seen = 1'b1;
        fire = req_valid & req_ready;
        if (track_idle && busy === 1'b0 && src_pending()) idle_cnt++;
        if (exp_grant_chk != '0 && fire != '0) check("fire_owner", fire, exp_grant_chk);
        if (tx_data_valid === 1'b1 && tx_data_ready === 1'b1) begin
            n_assert++;
            assert (sb.size() != 0) else begin
                n_fail++;
                $error("FAIL tx_extra: observed byte %02h expected no byte", tx_data);
            end
            if (sb.size() != 0) begin
                exp_b = sb.pop_front();
                check("tx_byte", tx_data, exp_b);
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NumReq; i++) begin
            if (fire[i] === 1'b1 && src_q[i].size() > 0) void'(src_q[i].pop_front());
        end
        drive();
    endtask

    task automatic run_until_done(input string tag, input int max_cyc);
        int   n;
        logic done;
        n    = 0;
        done = !(src_pending() || sb.size() != 0 || tx_data_valid !== 1'b0);
        while (!done && n < max_cyc) begin
            cycle();
            n++;
            done = !(src_pending() || sb.size() != 0 || tx_data_valid !== 1'b0);
        end
        check(tag, done, 1'b1);
    endtask

    task automatic wait_src(input string tag, input int idx, input int size, input int max_cyc);
        int n;
        n = 0;
        while (src_q[idx].size() != size && n < max_cyc) begin
            cycle();
            n++;
        end
        check(tag, src_q[idx].size(), size);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        string msg;
        int    n;

        rst           = 1'b1;
        tx_data_ready = 1'b1;
        drive();
        repeat (2) @(posedge clk);
        #1;
        check("rst_txv", tx_data_valid, 1'b0);
        check("rst_txd", tx_data, 8'h00);
        check("rst_grant", grant, 3'b000);
        check("rst_busy", busy, 1'b0);
        check("rst_to", timeout_flag, 1'b0);
        check("rst_ready", req_ready, 3'b000);
        rst = 1'b0;

        // Contention with rr_ptr=0: req0 packet first, one idle cycle, then req2.
        for (int i = 0; i < 3; i++) begin
            push_byte(0, 8'hC0 + 8'(i), i == 2);
            push_byte(2, 8'hE0 + 8'(i), i == 2);
        end
        for (int i = 0; i < 3; i++) sb.push_back(8'hC0 + 8'(i));
        for (int i = 0; i < 3; i++) sb.push_back(8'hE0 + 8'(i));
        drive();
        idle_cnt   = 0;
        track_idle = 1'b1;
        run_until_done("contention_done", 60);
        track_idle = 1'b0;
        // Initial arbitration plus exactly one re-arbitration cycle.
        check("contention_idle", idle_cnt, 2);

        // Single requester: "HELLO ALINX\r\n" from req1.
        msg = "HELLO ALINX";
        for (int i = 0; i < msg.len(); i++) begin
            push_byte(1, msg[i], 1'b0);
            sb.push_back(msg[i]);
        end
        push_byte(1, 8'h0D, 1'b0);
        sb.push_back(8'h0D);
        push_byte(1, 8'h0A, 1'b1);
        sb.push_back(8'h0A);
        exp_grant_chk = 3'b010;
        drive();
        cycle();
        check("lat_idle_grant", s_grant, 3'b000);
        check("lat_idle_ready", s_ready, 3'b000);
        cycle();
        check("lat_grant", s_grant, 3'b010);
        check("lat_ready", s_ready, 3'b010);
        check("lat_txv_lo", s_txv, 1'b0);
        cycle();
        check("lat_txv_hi", s_txv, 1'b1);
        check("lat_txd", s_txd, 8'h48);
        run_until_done("single_done", 60);
        exp_grant_chk = '0;
        cycle();
        check("single_grant_end", s_grant, 3'b000);
        check("single_busy_end", s_busy, 1'b0);

        // rr_ptr should now be 2: req2 beats req0.
        push_byte(0, 8'h50, 1'b1);
        push_byte(2, 8'h52, 1'b1);
        sb.push_back(8'h52);
        sb.push_back(8'h50);
        drive();
        run_until_done("ptr_done", 30);

        // Reset after byte 2 of 5 from req2; the pending byte must be discarded.
        for (int i = 0; i < 5; i++) push_byte(2, 8'h60 + 8'(i), i == 4);
        sb.push_back(8'h60);
        drive();
        wait_src("rst_mid_wait", 2, 3, 20);
        check("rst_mid_pending", tx_data_valid, 1'b1);
        rst = 1'b1;
        #1;
        check("rst_mid_txv", tx_data_valid, 1'b0);
        check("rst_mid_txd", tx_data, 8'h00);
        check("rst_mid_grant", grant, 3'b000);
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_ready", req_ready, 3'b000);
        check("rst_mid_sb", sb.size(), 0);
        src_q[2].delete();
        drive();
        repeat (2) cycle();
        rst = 1'b0;
        // Pointer restarts at 0: req0 wins over req2.
        push_byte(0, 8'h70, 1'b1);
        push_byte(2, 8'h72, 1'b1);
        sb.push_back(8'h70);
        sb.push_back(8'h72);
        drive();
        run_until_done("post_rst_done", 30);

        // Fairness with rr_ptr=0: 30,31,32,30,31,32.
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 3; i++) begin
                push_byte(i, 8'h30 + 8'(i), 1'b1);
                sb.push_back(8'h30 + 8'(i));
            end
        end
        drive();
        run_until_done("fair_done", 60);

        // Backpressure: output held 20 cycles, then drains A5, 5A in order.
        tx_data_ready = 1'b0;
        push_byte(0, 8'hA5, 1'b0);
        push_byte(0, 8'h5A, 1'b1);
        sb.push_back(8'hA5);
        sb.push_back(8'h5A);
        exp_grant_chk = 3'b001;
        drive();
        repeat (2) cycle();
        for (int i = 0; i < 20; i++) begin
            cycle();
            check("bp_txd", s_txd, 8'hA5);
            check("bp_txv", s_txv, 1'b1);
            check("bp_ready0", s_ready[0], 1'b0);
        end
        tx_data_ready = 1'b1;
        run_until_done("bp_done", 20);
        exp_grant_chk = '0;

        // Stall mid-packet: req1 owns (rr_ptr=1) and drops valid with req2 pending.
        push_byte(1, 8'h80, 1'b0);
        push_byte(1, 8'h81, 1'b1);
        push_byte(2, 8'h82, 1'b1);
        drive();
        wait_src("stall_wait", 1, 1, 20);
        en[1] = 1'b0;
        drive();
`ifdef UART_ARB_TIMEOUT_EN
        sb.push_back(8'h80);
        sb.push_back(8'h82);
        sb.push_back(8'h81);
        // The 16th stall cycle closes on an edge; the pulse shows in the cycle after it.
        n = 0;
        s_to = 1'b0;
        while (s_to !== 1'b1 && n < 40) begin
            cycle();
            n++;
        end
        check("to_cycle", n, 17);
        check("to_grant_rel", s_grant, 3'b000);
        cycle();
        check("to_pulse_end", s_to, 1'b0);
        check("to_grant_req2", s_grant, 3'b100);
`else
        sb.push_back(8'h80);
        sb.push_back(8'h81);
        sb.push_back(8'h82);
        n = 0;
        repeat (40) cycle();
        check("hold_grant", s_grant, 3'b010);
        check("hold_busy", s_busy, 1'b1);
        check("hold_no_to", to_seen, 1'b0);
`endif
        en[1] = 1'b1;
        drive();
        run_until_done("stall_done", 40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
